fifo_wr_arbiter: RTL

- Round-robin write-port arbiter sharing one FIFO write port among NREQ requesters.
- Each requester presents a valid/ready stream. The winner holds the port for a burst of up to MAX_BURST beats.
- Writes are throttled by the FIFO's full and almost_full flags. Sits on the write-clock side, directly in front of the FIFO write port.

---
 rtl/fifo_wr_arbiter_pkg.sv | 13 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 29 ++
 rtl/fifo_wr_arbiter.sv | 107 ++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types for the FIFO write-port arbiter and its round-robin picker.
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of valid scanning ptr, ptr+1, ... mod N.
module fifo_wr_arbiter_rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter  int N  = 4,
  localparam int PW = ptr_width(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  winner,
  output logic          found
);

  logic [PW-1:0] idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!found && valid[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ valid/ready requesters,
// with bursts of up to MAX_BURST beats and throttling on full/almost_full.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DSIZE     = 8,
  parameter int MAX_BURST = 4,
  parameter int BSIZE     = 4
) (
  input  logic                    wr_clk,
  input  logic                    wr_rst,
  input  logic                    arb_en,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*DSIZE-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         grant,
  output logic                    fifo_wr_en,
  output logic [DSIZE-1:0]        fifo_wr_data,
  input  logic                    fifo_full,
  input  logic                    fifo_almost_full,
  output logic                    busy
);

  localparam int PW = ptr_width(NREQ);

  state_t            state;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     owner;
  logic [BSIZE-1:0]  beat_cnt;

  logic [NREQ-1:0]   pick;
  logic              found;
  logic [PW-1:0]     pick_idx;
  logic [PW-1:0]     next_ptr;
  logic              can_wr;
  logic              owner_valid;
  logic              accept;
  logic              last_beat;
  logic [DSIZE-1:0]  owner_data;

  fifo_wr_arbiter_rr_pick #(.N(NREQ)) u_pick (
    .valid  (req_valid),
    .ptr    (rr_ptr),
    .winner (pick),
    .found  (found)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) pick_idx = PW'(i);
    end
  end

  // Both flags gate writes; the output register adds a cycle that ALMOST>=2 absorbs.
  assign can_wr      = !fifo_full && !fifo_almost_full;
  assign owner_valid = |(grant & req_valid);
  assign req_ready   = (state == BURST) ? (grant & req_valid & {NREQ{can_wr}}) : '0;
  assign accept      = |req_ready;
  assign last_beat   = (beat_cnt == BSIZE'(MAX_BURST - 1));
  assign owner_data  = req_data[int'(owner)*DSIZE +: DSIZE];
  assign next_ptr    = (owner == PW'(NREQ - 1)) ? '0 : owner + 1'b1;

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      state        <= IDLE;
      grant        <= '0;
      owner        <= '0;
      rr_ptr       <= '0;
      beat_cnt     <= '0;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
      busy         <= 1'b0;
    end else begin
      fifo_wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_en && found) begin
            state    <= BURST;
            grant    <= pick;
            owner    <= pick_idx;
            beat_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        BURST: begin
          if (accept) begin
            fifo_wr_en   <= 1'b1;
            fifo_wr_data <= owner_data;
            beat_cnt     <= beat_cnt + 1'b1;
          end
          // Owner dropping valid forfeits the grant even if it never got a beat in.
          if (!owner_valid || (accept && last_beat)) begin
            state    <= IDLE;
            grant    <= '0;
            rr_ptr   <= next_ptr;
            beat_cnt <= '0;
            busy     <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
